// File: rtl/multiply_accumulate_unit_if.sv
// Handshake and operand bundle for the iterative multiply-accumulate unit.
// The master side issues operations; the slave side is the unit itself.
interface multiply_accumulate_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [3:0]         opcode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic [WIDTH-1:0]   d;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               illegal;

  modport master (
    output start, opcode, a, b, c, d,
    input  busy, done, result, illegal
  );

  modport slave (
    input  start, opcode, a, b, c, d,
    output busy, done, result, illegal
  );
endinterface

// File: rtl/multiply_accumulate_unit.sv
// Iterative shift-add multiply-accumulate unit. It retires STEP multiplier bits per cycle;
// signed forms run on magnitudes and negate the finished product.
module multiply_accumulate_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input logic                     clk,
  input logic                     rst,
  multiply_accumulate_unit_if.slave bus
);

  localparam int unsigned NumSteps = WIDTH / STEP;
  localparam int unsigned CntW     = $clog2(NumSteps) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pp_q, pp_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               neg_q, neg_d;
  logic               long_q, long_d;
  logic               acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               illegal_q, illegal_d;

  logic op_legal, op_signed, op_long, op_acc;

  always_comb begin
    op_legal  = 1'b0;
    op_signed = 1'b0;
    op_long   = 1'b0;
    op_acc    = 1'b0;
    case (bus.opcode)
      4'b0000: op_legal = 1'b1;
      4'b0001: begin op_legal = 1'b1; op_acc = 1'b1; end
      4'b0100: begin op_legal = 1'b1; op_long = 1'b1; end
      4'b0101: begin op_legal = 1'b1; op_long = 1'b1; op_acc = 1'b1; end
      4'b0110: begin op_legal = 1'b1; op_long = 1'b1; op_signed = 1'b1; end
      4'b0111: begin op_legal = 1'b1; op_long = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      default: op_legal = 1'b0;
    endcase
  end

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // One shift-add step: add mcand * (low STEP multiplier bits) into the high half, shift right.
  logic [WIDTH+STEP-1:0]   addend, step_sum;
  logic [2*WIDTH+STEP-1:0] shifted;
  logic [2*WIDTH-1:0]      pp_next, prod, final_res;
  logic [WIDTH-1:0]        short_res;

  always_comb begin
    addend    = (WIDTH+STEP)'(mcand_q) * (WIDTH+STEP)'(mplier_q[STEP-1:0]);
    step_sum  = (WIDTH+STEP)'(pp_q[2*WIDTH-1:WIDTH]) + addend;
    shifted   = {step_sum, pp_q[WIDTH-1:0]};
    pp_next   = shifted[2*WIDTH+STEP-1:STEP];
    prod      = neg_q ? (~pp_next + (2*WIDTH)'(1)) : pp_next;
    short_res = prod[WIDTH-1:0] + (acc_q ? c_q : '0);
    if (long_q) begin
      final_res = prod + (acc_q ? {c_q, d_q} : '0);
    end else begin
      final_res = {{WIDTH{1'b0}}, short_res};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pp_d      = pp_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    c_d       = c_q;
    d_d       = d_q;
    neg_d     = neg_q;
    long_d    = long_q;
    acc_d     = acc_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (op_legal) begin
            mcand_d  = magnitude(bus.a, op_signed);
            mplier_d = magnitude(bus.b, op_signed);
            neg_d    = op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            long_d   = op_long;
            acc_d    = op_acc;
            c_d      = bus.c;
            d_d      = bus.d;
            cnt_d    = '0;
            pp_d     = '0;
            state_d  = StRun;
          end else begin
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StRun: begin
        pp_d     = pp_next;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NumSteps - 1)) begin
          result_d  = final_res;
          illegal_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pp_q      <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      c_q       <= '0;
      d_q       <= '0;
      neg_q     <= 1'b0;
      long_q    <= 1'b0;
      acc_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pp_q      <= pp_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      c_q       <= c_d;
      d_q       <= d_d;
      neg_q     <= neg_d;
      long_q    <= long_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.result  = result_q;
  assign bus.illegal = illegal_q;

endmodule
